// File: rtl/jpeg_seg_rle_sequencer.sv
// JPEG AC run-length sequencer: turns merged 8-coefficient segment summaries into
// (run, value) symbols, carrying zero runs across segments and inserting ZRL/EOB.
module jpeg_seg_rle_sequencer #(
  parameter int unsigned SEG_LEN = 8,
  parameter int unsigned ENT_W   = 14,
  parameter int unsigned VAL_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     seg_valid,
  output logic                     seg_ready,
  input  logic [2:0]               seg_left,
  input  logic [2:0]               seg_right,
  input  logic                     seg_flag,
  input  logic [SEG_LEN*ENT_W-1:0] seg_array,
  input  logic [3:0]               seg_size,
  input  logic                     seg_last,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic [3:0]               sym_run,
  output logic [VAL_W-1:0]         sym_value,
  output logic                     sym_eob
);

  localparam int unsigned ACC_W = 7;
  localparam int unsigned IDX_W = $clog2(SEG_LEN);
  localparam logic [ACC_W-1:0] ZRL_LEN = ACC_W'(16);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_EOB} state_t;

  typedef struct packed {
    logic [3:0]       run;
    logic [VAL_W-1:0] value;
  } sym_t;

  state_t           state;
  logic [ACC_W-1:0] carry;
  logic [ACC_W-1:0] run_acc;
  logic [IDX_W-1:0] idx;
  logic [ENT_W-1:0] ents_q [SEG_LEN];
  logic [2:0]       right_q;
  logic             last_q;

  logic [ENT_W-1:0] seg_ents [SEG_LEN];
  logic             seg_nz;
  logic [IDX_W-1:0] first_idx;
  logic [ENT_W-1:0] first_ent;
  logic [ACC_W-1:0] acc_first;
  logic [VAL_W-1:0] cur_val;
  logic [ENT_W-1:0] nxt_ent;
  logic [ACC_W-1:0] nxt_run;
  logic [ACC_W-1:0] zrl_left;
  logic             accept;
  logic             handshake;

  // A run of 16+ zeros must first be chipped down with ZRL symbols.
  function automatic sym_t coef_sym(input logic [ACC_W-1:0] r, input logic [VAL_W-1:0] v);
    sym_t s;
    if (r >= ZRL_LEN) begin
      s.run   = 4'd15;
      s.value = '0;
    end else begin
      s.run   = r[3:0];
      s.value = v;
    end
    return s;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < SEG_LEN; i++) begin
      seg_ents[i] = seg_array[i*ENT_W +: ENT_W];
    end
  end

  assign seg_ready = (state == S_IDLE) && !rst;
  assign accept    = seg_valid && seg_ready;
  assign handshake = sym_valid && sym_ready;

  // Size 0 with flag set is illegal and degrades to an all-zero segment.
  assign seg_nz    = seg_flag && (seg_size != 4'd0);
  assign first_idx = IDX_W'(seg_size - 4'd1);
  assign first_ent = seg_ents[first_idx];
  assign acc_first = carry + ACC_W'(seg_left) + ACC_W'(first_ent[ENT_W-1:VAL_W]);

  assign cur_val  = ents_q[idx][VAL_W-1:0];
  assign nxt_ent  = ents_q[idx - IDX_W'(1)];
  assign nxt_run  = ACC_W'(nxt_ent[ENT_W-1:VAL_W]);
  assign zrl_left = run_acc - ZRL_LEN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      carry     <= '0;
      run_acc   <= '0;
      idx       <= '0;
      right_q   <= '0;
      last_q    <= 1'b0;
      sym_valid <= 1'b0;
      sym_run   <= '0;
      sym_value <= '0;
      sym_eob   <= 1'b0;
      for (int unsigned i = 0; i < SEG_LEN; i++) begin
        ents_q[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            ents_q  <= seg_ents;
            right_q <= seg_right;
            last_q  <= seg_last;
            if (seg_nz) begin
              idx                  <= first_idx;
              run_acc              <= acc_first;
              carry                <= '0;
              state                <= S_EMIT;
              sym_valid            <= 1'b1;
              sym_eob              <= 1'b0;
              {sym_run, sym_value} <= coef_sym(acc_first, first_ent[VAL_W-1:0]);
            end else begin
              carry <= carry + ACC_W'(SEG_LEN);
              if (seg_last) begin
                state     <= S_EOB;
                sym_valid <= 1'b1;
                sym_eob   <= 1'b1;
                sym_run   <= '0;
                sym_value <= '0;
              end
            end
          end
        end

        S_EMIT: begin
          if (handshake) begin
            if (run_acc >= ZRL_LEN) begin
              run_acc              <= zrl_left;
              {sym_run, sym_value} <= coef_sym(zrl_left, cur_val);
            end else if (idx != '0) begin
              idx                  <= idx - IDX_W'(1);
              run_acc              <= nxt_run;
              {sym_run, sym_value} <= coef_sym(nxt_run, nxt_ent[VAL_W-1:0]);
            end else begin
              sym_run   <= '0;
              sym_value <= '0;
              // Trailing zeros of the final segment fold into EOB, unless there are none.
              if (last_q && (right_q != 3'd0)) begin
                carry     <= ACC_W'(right_q);
                state     <= S_EOB;
                sym_valid <= 1'b1;
                sym_eob   <= 1'b1;
              end else if (last_q) begin
                carry     <= '0;
                state     <= S_IDLE;
                sym_valid <= 1'b0;
              end else begin
                carry     <= ACC_W'(right_q);
                state     <= S_IDLE;
                sym_valid <= 1'b0;
              end
            end
          end
        end

        S_EOB: begin
          if (handshake) begin
            carry     <= '0;
            state     <= S_IDLE;
            sym_valid <= 1'b0;
            sym_eob   <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_seg_rle_sequencer.sv
// Directed scoreboard bench for jpeg_seg_rle_sequencer: expected symbols are queued
// when a segment is driven and compared as the sequencer hands them out.
module tb_jpeg_seg_rle_sequencer;

  localparam int unsigned SEG_LEN = 8;
  localparam int unsigned ENT_W   = 14;
  localparam int unsigned VAL_W   = 8;

  typedef struct packed {
    logic [3:0] run;
    logic [7:0] value;
    logic       eob;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     seg_valid;
  logic                     seg_ready;
  logic [2:0]               seg_left;
  logic [2:0]               seg_right;
  logic                     seg_flag;
  logic [SEG_LEN*ENT_W-1:0] seg_array;
  logic [3:0]               seg_size;
  logic                     seg_last;
  logic                     sym_valid;
  logic                     sym_ready;
  logic [3:0]               sym_run;
  logic [VAL_W-1:0]         sym_value;
  logic                     sym_eob;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  jpeg_seg_rle_sequencer #(.SEG_LEN(SEG_LEN), .ENT_W(ENT_W), .VAL_W(VAL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_valid (seg_valid),
    .seg_ready (seg_ready),
    .seg_left  (seg_left),
    .seg_right (seg_right),
    .seg_flag  (seg_flag),
    .seg_array (seg_array),
    .seg_size  (seg_size),
    .seg_last  (seg_last),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_run   (sym_run),
    .sym_value (sym_value),
    .sym_eob   (sym_eob)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] ent(input logic [5:0] run, input logic [7:0] val);
    return {run, val};
  endfunction

  // Slot 0 is the last entry in scan order.
  function automatic logic [111:0] arr3(input logic [13:0] e0, input logic [13:0] e1,
                                        input logic [13:0] e2);
    return {70'd0, e2, e1, e0};
  endfunction

  function automatic exp_t sym(input logic [3:0] run, input logic [7:0] val, input logic eob);
    exp_t e;
    e.run   = run;
    e.value = val;
    e.eob   = eob;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send_seg(input logic flag, input logic [2:0] left, input logic [2:0] right,
                          input logic [3:0] size, input logic [111:0] arr, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!seg_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("seg_ready_wait", 32'(seg_ready), 32'd1);
    seg_valid = 1'b1;
    seg_flag  = flag;
    seg_left  = left;
    seg_right = right;
    seg_size  = size;
    seg_array = arr;
    seg_last  = last;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
  endtask

  // Consume queued symbols; optionally hold sym_ready low for 5 cycles on symbol stall_at.
  task automatic drain(input int stall_at);
    int   n;
    int   guard;
    exp_t e;
    n     = 0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (sym_valid) begin
        if (n == stall_at) begin
          sym_ready = 1'b0;
          e = exp_q[0];
          repeat (5) begin
            @(negedge clk);
            check("stall_valid", 32'(sym_valid), 32'd1);
            check("stall_run", 32'(sym_run), 32'(e.run));
            check("stall_value", 32'(sym_value), 32'(e.value));
            check("stall_eob", 32'(sym_eob), 32'(e.eob));
            check("stall_seg_ready", 32'(seg_ready), 32'd0);
          end
          sym_ready = 1'b1;
        end
        e = exp_q.pop_front();
        check($sformatf("sym%0d_run", n), 32'(sym_run), 32'(e.run));
        check($sformatf("sym%0d_value", n), 32'(sym_value), 32'(e.value));
        check($sformatf("sym%0d_eob", n), 32'(sym_eob), 32'(e.eob));
        n++;
      end
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("no_extra_sym", 32'(sym_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    seg_valid = 1'b0;
    seg_left  = '0;
    seg_right = '0;
    seg_flag  = 1'b0;
    seg_array = '0;
    seg_size  = '0;
    seg_last  = 1'b0;
    sym_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_seg_ready", 32'(seg_ready), 32'd0);
    check("rst_sym_valid", 32'(sym_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_seg_ready", 32'(seg_ready), 32'd1);
    check("idle_sym_run", 32'(sym_run), 32'd0);
    check("idle_sym_value", 32'(sym_value), 32'd0);
    check("idle_sym_eob", 32'(sym_eob), 32'd0);

    // Two entries, left=2: (2,05) then (3,FD); right=1 carried
    exp_q.push_back(sym(4'd2, 8'h05, 1'b0));
    exp_q.push_back(sym(4'd3, 8'hFD, 1'b0));
    send_seg(1'b1, 3'd2, 3'd1, 4'd2, arr3(ent(6'd3, 8'hFD), ent(6'd0, 8'h05), 14'd0), 1'b0);
    drain(-1);

    // All-zero segment: carry 1+8=9, then left 7 gives run 16 -> ZRL then (0,11)
    send_seg(1'b0, 3'd0, 3'd0, 4'd0, '0, 1'b0);
    drain(-1);
    exp_q.push_back(sym(4'd15, 8'h00, 1'b0));
    exp_q.push_back(sym(4'd0, 8'h11, 1'b0));
    send_seg(1'b1, 3'd7, 3'd0, 4'd1, arr3(ent(6'd0, 8'h11), 14'd0, 14'd0), 1'b0);
    drain(-1);

    // Block with only segment 0 nonzero: (0,01) then EOB after the 8th segment
    exp_q.push_back(sym(4'd0, 8'h01, 1'b0));
    send_seg(1'b1, 3'd0, 3'd7, 4'd1, arr3(ent(6'd0, 8'h01), 14'd0, 14'd0), 1'b0);
    drain(-1);
    for (int s = 1; s < 7; s++) begin
      send_seg(1'b0, 3'd0, 3'd0, 4'd0, '0, 1'b0);
      drain(-1);
    end
    exp_q.push_back(sym(4'd0, 8'h00, 1'b1));
    send_seg(1'b0, 3'd0, 3'd0, 4'd0, '0, 1'b1);
    drain(-1);

    // Block ends on coefficient 63: (3,7F), no EOB, carry cleared by prior EOB
    exp_q.push_back(sym(4'd3, 8'h7F, 1'b0));
    send_seg(1'b1, 3'd3, 3'd0, 4'd1, arr3(ent(6'd0, 8'h7F), 14'd0, 14'd0), 1'b1);
    drain(-1);
    check("seg_ready_after_last", 32'(seg_ready), 32'd1);

    // Stall 5 cycles on the second symbol; entry run 20 forces a ZRL before (4,23)
    exp_q.push_back(sym(4'd1, 8'h21, 1'b0));
    exp_q.push_back(sym(4'd2, 8'h22, 1'b0));
    exp_q.push_back(sym(4'd15, 8'h00, 1'b0));
    exp_q.push_back(sym(4'd4, 8'h23, 1'b0));
    send_seg(1'b1, 3'd1, 3'd0, 4'd3,
             arr3(ent(6'd20, 8'h23), ent(6'd2, 8'h22), ent(6'd0, 8'h21)), 1'b0);
    drain(1);

    // Reset while a symbol is stalled in EMIT, then a fresh segment sees no carry
    send_seg(1'b0, 3'd0, 3'd0, 4'd0, '0, 1'b0);
    drain(-1);
    sym_ready = 1'b0;
    send_seg(1'b1, 3'd5, 3'd5, 4'd1, arr3(ent(6'd0, 8'h33), 14'd0, 14'd0), 1'b0);
    @(negedge clk);
    check("abort_pre_valid", 32'(sym_valid), 32'd1);
    check("abort_pre_run", 32'(sym_run), 32'd13);
    check("abort_pre_seg_ready", 32'(seg_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_sym_valid", 32'(sym_valid), 32'd0);
    check("abort_seg_ready", 32'(seg_ready), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    sym_ready = 1'b1;
    #1;
    check("abort_release_ready", 32'(seg_ready), 32'd1);
    exp_q.push_back(sym(4'd4, 8'h44, 1'b0));
    send_seg(1'b1, 3'd4, 3'd0, 4'd1, arr3(ent(6'd0, 8'h44), 14'd0, 14'd0), 1'b1);
    drain(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jpeg_seg_rle_sequencer.md
Name: jpeg_seg_rle_sequencer

Overview:
Sequential back end for the 8-coefficient zero-merge datapath. Accepts one merged 8-coefficient segment summary per handshake (edge zero counts, nonzero flag, packed entry array, size) and carries zero runs across segment boundaries. Serialises each entry as a JPEG AC (run, value) symbol, inserting ZRL (15,0) for runs of 16 or more and EOB at block end. Sits between the segment merge tree and the Huffman encoder. Eight segments make one 64-coefficient block.

Parameters:
SEG_LEN, 8, coefficients per segment; also the max entry count.
ENT_W, 14, entry width: {run[5:0], value[7:0]}.
VAL_W, 8, coefficient value width.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
seg_valid  input  1  segment summary valid
seg_ready  output  1  high only in IDLE (0 while rst high)
seg_left  input  3  zeros before the first nonzero in the segment
seg_right  input  3  zeros after the last nonzero in the segment
seg_flag  input  1  0 = all eight coefficients zero
seg_array  input  SEG_LEN*ENT_W  packed entries; entry size-1 in the highest used slot is the first in scan order; entry 0 at [13:0] is the last
seg_size  input  4  valid entries, 0..8
seg_last  input  1  segment is the 8th of the block
sym_valid  output  1  symbol valid
sym_ready  input  1  downstream accepts symbol
sym_run  output  4  zero run, 0..15
sym_value  output  VAL_W  coefficient; 0 for ZRL and EOB
sym_eob  output  1  symbol is EOB (run 0, value 0)

Behaviour:
- Reset values:
  - state IDLE, carry=0, run_acc=0, idx=0.
  - sym_valid=0, sym_run=0, sym_value=0, sym_eob=0.
  - All latched segment fields are 0.
- Registers:
  - carry: 7 bits, zeros pending from earlier segments of the current block.
  - run_acc: 7 bits, zeros preceding the current entry.
  - idx: 3 bits, current entry index.
- FSM states: IDLE, EMIT, EOB.
- Segment acceptance: only in IDLE when seg_valid and seg_ready are both high. All seg_* fields are latched on the same edge.
- Accept with flag=0:
  - carry += 8.
  - If seg_last, go to EOB; otherwise stay in IDLE.
- Accept with flag=1:
  - idx = size-1.
  - run_acc = carry + seg_left + array[idx].run.
  - carry = 0; go to EMIT.
  - The first symbol is valid on the next cycle (latency 1).
- Accept with flag=1 and size=0 is illegal. The block treats it as flag=0.
- EMIT output:
  - If run_acc >= 16: present ZRL (run 15, value 0, eob 0).
  - Otherwise: present (run_acc[3:0], array[idx].value).
- EMIT, on sym_valid && sym_ready:
  - After a ZRL: run_acc -= 16; stay in EMIT.
  - After a coefficient with idx>0: idx -= 1; run_acc = array[idx-1].run.
  - After a coefficient with idx=0: carry = latched seg_right.
    - If the latched last is set and seg_right>0, go to EOB.
    - If the latched last is set and seg_right=0, clear carry and go to IDLE (block ended on coefficient 63; no EOB).
    - If last is not set, go to IDLE.
- EOB state: present run 0, value 0, eob 1. On handshake, carry=0 and go to IDLE.
- Output stability: sym_* are register-driven. While sym_valid && !sym_ready they hold stable and no state advances.
- ZRL placement: ZRL is only ever emitted immediately before a nonzero coefficient. Trailing zeros of a block are never emitted as ZRL; they fold into EOB.
- Arithmetic: run totals never exceed 63 within a legal block; the 7-bit accumulators cannot overflow. No saturation logic.
- seg_ready is low in EMIT and EOB; inputs are ignored there.
- Reset mid-block: aborts immediately. In-flight symbols and carry are discarded and the block restarts at IDLE.

Test Plan:
1. Reset asserted during EMIT with sym_ready=0 -> sym_valid=0 on the same cycle. After release, seg_ready=1, carry=0, and the next segment's first run equals its seg_left only.
2. Segment flag=1, left=2, right=1, size=2; entries (first) {0,0x05} and (second) {3,0xFD}; last=0 -> symbols (2,0x05) then (3,0xFD); carry=1; returns to IDLE.
3. Following segment flag=0 -> carry=9, no symbols. Then segment flag=1, left=7, size=1, entry {0,0x11}, right=0 -> ZRL (15,0) then (0,0x11).
4. Eight segments, only segment 0 nonzero (left=0, entry {0,0x01}, right=7, size=1), rest flag=0 with the 8th last=1 -> symbols (0,0x01), then EOB (sym_eob=1); carry=0 afterwards.
5. Final segment flag=1, right=0, last=1, last entry value 0x7F -> (run,0x7F) is emitted and no EOB follows; seg_ready is high on the next cycle.
6. sym_ready held low for 5 cycles mid-segment -> sym_run, sym_value and sym_eob stay constant; seg_ready stays 0; the symbol sequence is identical to the no-stall run.
